mux_select_context_cell: RTL

//  Upstream configuration stage for the 32b 4:1 routing mux: drives its 2-bit select.

---
 rtl/cgra_cfg_pkg.sv | 39 +++
 rtl/cfg_shift_chain.sv | 45 ++++
 rtl/mux_select_context_cell.sv | 83 ++++++++
 3 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared CGRA configuration definitions: default select width, chain sizing helpers
// and the select word type used by context-switched routing cells.
package cgra_cfg_pkg;

  localparam int unsigned CGRA_SEL_WIDTH = 2;
  localparam int unsigned CGRA_CONTEXTS  = 4;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned chain_len(input int unsigned sel_width,
                                            input int unsigned contexts);
    return sel_width * contexts;
  endfunction

  function automatic int unsigned ctx_width(input int unsigned contexts);
    return (contexts <= 1) ? 1 : clog2(contexts);
  endfunction

  // Counter must reach CHAIN_LEN+1 so an over-long load is distinguishable.
  function automatic int unsigned cnt_width(input int unsigned len);
    return clog2(len + 2);
  endfunction

  localparam int unsigned CGRA_CHAIN_LEN = chain_len(CGRA_SEL_WIDTH, CGRA_CONTEXTS);

  typedef logic [CGRA_SEL_WIDTH-1:0] sel_word_t;

endpackage

// File: rtl/cfg_shift_chain.sv
// Shadow configuration shift register with a saturating count of bits shifted
// since the last clear; bits enter at the MSB and leave from bit 0.
module cfg_shift_chain
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CGRA_CHAIN_LEN,
  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 din,
  output logic                 dout,
  output logic [CHAIN_LEN-1:0] q,
  output logic [CNT_W-1:0]     cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] q_next;

  // Right shift with din entering at the top; works down to a 1-bit chain.
  always_comb begin
    q_next = CHAIN_LEN'({din, q} >> 1);
  end

  // A clear coinciding with a shift leaves the count at 1: that bit belongs to the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      if (en) q <= q_next;
      if (clr) begin
        cnt <= CNT_W'(en);
      end else if (en && (cnt != CNT_SAT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign dout = q[0];

endmodule

// File: rtl/mux_select_context_cell.sv
// Double-buffered select configuration for a routing mux: serial shadow load,
// atomic commit into the active bank, and a context counter stepping through words.
module mux_select_context_cell
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = CGRA_SEL_WIDTH,
  parameter int unsigned CONTEXTS  = CGRA_CONTEXTS,
  localparam int unsigned CHAIN_LEN = chain_len(SEL_WIDTH, CONTEXTS),
  localparam int unsigned CTX_W     = ctx_width(CONTEXTS)
) (
  input  logic                 CGRA_Clock,
  input  logic                 CGRA_Reset_n,
  input  logic                 ConfigIn,
  output logic                 ConfigOut,
  input  logic                 config_enable,
  input  logic                 config_commit,
  input  logic                 run_enable,
  output logic [SEL_WIDTH-1:0] select,
  output logic [CTX_W-1:0]     context_idx,
  output logic                 config_valid,
  output logic                 config_error
);

  localparam int unsigned      CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CTX_W-1:0] CTX_LAST = CTX_W'(CONTEXTS - 1);

  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CTX_W-1:0]     ctx;
  logic [CTX_W-1:0]     ctx_next;

  cfg_shift_chain #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .clk   (CGRA_Clock),
    .rst_n (CGRA_Reset_n),
    .en    (config_enable),
    .clr   (config_commit),
    .din   (ConfigIn),
    .dout  (ConfigOut),
    .q     (shadow),
    .cnt   (bit_cnt)
  );

  // Commit restarts the context sequence and takes priority over stepping.
  always_comb begin
    ctx_next = ctx;
    if (config_commit) begin
      ctx_next = '0;
    end else if (run_enable) begin
      ctx_next = (ctx == CTX_LAST) ? '0 : ctx + CTX_W'(1);
    end
  end

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset_n) begin
      active       <= '0;
      ctx          <= '0;
      config_valid <= 1'b0;
      config_error <= 1'b0;
    end else begin
      ctx <= ctx_next;
      if (config_commit) begin
        active       <= shadow;
        config_valid <= 1'b1;
        config_error <= (bit_cnt != CNT_FULL);
      end
    end
  end

  // Word selection decoded from registers only, so shifting cannot glitch the mux.
  always_comb begin
    select = '0;
    for (int unsigned i = 0; i < CONTEXTS; i++) begin
      if (ctx == CTX_W'(i)) select = active[i*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  assign context_idx = ctx;

endmodule
